// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet widths and packet-type codes used by the
// arbiter, packet_picker and packet_assembler.
package hdmi_packet_pkg;

  localparam int HEADER_W = 24;
  localparam int SUB_W    = 224;

  localparam logic [HEADER_W-1:0] NULL_HEADER = 24'h0;
  localparam logic [SUB_W-1:0]    NULL_SUB    = 224'h0;

  localparam logic [7:0] ACR            = 8'h01;
  localparam logic [7:0] AUDIO_SAMPLE   = 8'h02;
  localparam logic [7:0] INFOFRAME_BASE = 8'h80;

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating-priority one-hot encoder: the first set request at or after ptr
// (wrapping) wins.
module rr_priority_encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic         any
);

  logic [W-1:0] idx_s;

  // Scan from ptr upward and keep only the first hit.
  always_comb begin
    gnt   = '0;
    any   = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = W'((int'(ptr) + k) % N);
      if (!any && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        any        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/packet_slot_arbiter.sv
// Grants one packet source per data-island slot: urgent fixed priority, then
// unserved deadline sources round-robin, then everything else round-robin.
module packet_slot_arbiter
  import hdmi_packet_pkg::*;
#(
  parameter  int                 NUM_REQ       = 4,
  parameter  logic [NUM_REQ-1:0] URGENT_MASK   = 4'b0001,
  parameter  logic [NUM_REQ-1:0] DEADLINE_MASK = 4'b0110,
  localparam int                 ID_W          = $clog2(NUM_REQ)
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  input  logic                        packet_enable,
  input  logic                        video_field_end,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*HEADER_W-1:0] req_header,
  input  logic [NUM_REQ*SUB_W-1:0]    req_sub,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic [HEADER_W-1:0]         header,
  output logic [SUB_W-1:0]            sub,
  output logic [NUM_REQ-1:0]          missed_deadline
);

  logic [NUM_REQ-1:0]  ack_q, sent_q, missed_q;
  logic                grant_valid_q;
  logic [ID_W-1:0]     grant_id_q, rr_ptr_q;
  logic [HEADER_W-1:0] header_q;
  logic [SUB_W-1:0]    sub_q;

  logic [NUM_REQ-1:0]  elig_s, urg_s, urg_gnt_s, dl_s, dl_gnt_s, any_gnt_s;
  logic                dl_any_s, any_any_s;
  logic [NUM_REQ-1:0]  gnt_d, grant_now_s;
  logic                rr_grant_d, valid_d;
  logic [ID_W-1:0]     id_d, rr_ptr_d;
  logic [HEADER_W-1:0] header_d;
  logic [SUB_W-1:0]    sub_d;

  // A source acked last cycle still shows req this cycle; mask it out.
  assign elig_s    = req & ~ack_q;
  assign urg_s     = elig_s & URGENT_MASK;
  assign urg_gnt_s = urg_s & (~urg_s + NUM_REQ'(1));
  assign dl_s      = elig_s & DEADLINE_MASK & ~sent_q;

  rr_priority_encoder #(.N(NUM_REQ)) u_rr_deadline (
    .req (dl_s),
    .ptr (rr_ptr_q),
    .gnt (dl_gnt_s),
    .any (dl_any_s)
  );

  rr_priority_encoder #(.N(NUM_REQ)) u_rr_general (
    .req (elig_s),
    .ptr (rr_ptr_q),
    .gnt (any_gnt_s),
    .any (any_any_s)
  );

  // Class selection and one-hot to index/payload mux.
  always_comb begin
    if (|urg_s) begin
      gnt_d      = urg_gnt_s;
      rr_grant_d = 1'b0;
    end else if (dl_any_s) begin
      gnt_d      = dl_gnt_s;
      rr_grant_d = 1'b1;
    end else begin
      gnt_d      = any_gnt_s;
      rr_grant_d = any_any_s;
    end
    valid_d  = |gnt_d;
    id_d     = '0;
    header_d = NULL_HEADER;
    sub_d    = NULL_SUB;
    for (int i = 0; i < NUM_REQ; i++) begin
      id_d     = id_d | (gnt_d[i] ? ID_W'(i) : '0);
      header_d = header_d | ({HEADER_W{gnt_d[i]}} & req_header[i*HEADER_W +: HEADER_W]);
      sub_d    = sub_d | ({SUB_W{gnt_d[i]}} & req_sub[i*SUB_W +: SUB_W]);
    end
    rr_ptr_d = (id_d == ID_W'(NUM_REQ - 1)) ? '0 : id_d + ID_W'(1);
  end

  assign grant_now_s = packet_enable ? gnt_d : '0;

  // Slot registers, round-robin pointer and per-field delivery bookkeeping.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      ack_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      header_q      <= NULL_HEADER;
      sub_q         <= NULL_SUB;
      rr_ptr_q      <= '0;
      sent_q        <= '0;
      missed_q      <= '0;
    end else begin
      ack_q <= '0;
      if (packet_enable) begin
        ack_q         <= gnt_d;
        grant_valid_q <= valid_d;
        header_q      <= header_d;
        sub_q         <= sub_d;
        if (valid_d) grant_id_q <= id_d;
        if (rr_grant_d) rr_ptr_q <= rr_ptr_d;
      end
      // A grant in the field-end cycle is credited to the field that is ending.
      if (video_field_end) begin
        missed_q <= missed_q | (DEADLINE_MASK & ~(sent_q | grant_now_s));
        sent_q   <= '0;
      end else begin
        sent_q <= sent_q | grant_now_s;
      end
    end
  end

  assign ack             = ack_q;
  assign grant_valid     = grant_valid_q;
  assign grant_id        = grant_id_q;
  assign header          = header_q;
  assign sub             = sub_q;
  assign missed_deadline = missed_q;

endmodule

// File: tb/tb_packet_slot_arbiter.sv
// Directed, table-driven bench for packet_slot_arbiter, plus a second instance
// with a widened urgent mask for the starved-deadline case.
module tb_packet_slot_arbiter;

  logic         clk_pixel = 1'b0;
  logic         reset, pe, fe, pe2, fe2;
  logic [3:0]   req, req2;
  logic [95:0]  req_header;
  logic [895:0] req_sub;
  logic [3:0]   ack, ack2, missed, missed2;
  logic         valid, valid2;
  logic [1:0]   gid, gid2;
  logic [23:0]  header, header2;
  logic [223:0] sub, sub2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       vld;
    logic [1:0] id;
    logic [1:0] rr;
  } vec_t;
  vec_t tbl[11];

  always #5 clk_pixel = ~clk_pixel;

  packet_slot_arbiter dut (
    .clk_pixel(clk_pixel), .reset(reset), .packet_enable(pe), .video_field_end(fe),
    .req(req), .req_header(req_header), .req_sub(req_sub), .ack(ack),
    .grant_valid(valid), .grant_id(gid), .header(header), .sub(sub),
    .missed_deadline(missed)
  );

  packet_slot_arbiter #(.NUM_REQ(4), .URGENT_MASK(4'b0011), .DEADLINE_MASK(4'b0110)) dut2 (
    .clk_pixel(clk_pixel), .reset(reset), .packet_enable(pe2), .video_field_end(fe2),
    .req(req2), .req_header(req_header), .req_sub(req_sub), .ack(ack2),
    .grant_valid(valid2), .grant_id(gid2), .header(header2), .sub(sub2),
    .missed_deadline(missed2)
  );

  function automatic logic [23:0] hdr_of(input int i);
    return 24'h80BE00 | 24'(i);
  endfunction

  function automatic logic [223:0] sub_of(input int i);
    logic [31:0] w;
    w = 32'hA5C30000 | 32'(i + 1);
    return {7{w}};
  endfunction

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_ack;
    reset = 1'b1; pe = 1'b0; fe = 1'b0; req = 4'b0;
    pe2 = 1'b0; fe2 = 1'b0; req2 = 4'b0;
    for (int i = 0; i < 4; i++) begin
      req_header[i*24 +: 24] = hdr_of(i);
      req_sub[i*224 +: 224]  = sub_of(i);
    end

    tbl[0]  = '{4'b0000, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{4'b0110, 1'b1, 2'd1, 2'd2};
    tbl[2]  = '{4'b0110, 1'b1, 2'd2, 2'd3};
    tbl[3]  = '{4'b0110, 1'b1, 2'd1, 2'd2};
    tbl[4]  = '{4'b0110, 1'b1, 2'd2, 2'd3};
    tbl[5]  = '{4'b0000, 1'b0, 2'd2, 2'd3};
    tbl[6]  = '{4'b1001, 1'b1, 2'd0, 2'd3};
    tbl[7]  = '{4'b1000, 1'b1, 2'd3, 2'd0};
    tbl[8]  = '{4'b1110, 1'b1, 2'd1, 2'd2};
    tbl[9]  = '{4'b1111, 1'b1, 2'd0, 2'd2};
    tbl[10] = '{4'b1100, 1'b1, 2'd2, 2'd3};

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 224'(valid), 224'(1'b0));
    chk("rst_ack", 224'(ack), 224'(4'b0));
    chk("rst_header", 224'(header), 224'(24'h0));
    chk("rst_sub", sub, 224'h0);
    chk("rst_missed", 224'(missed), 224'(4'b0));
    chk("rst_rr", 224'(dut.rr_ptr_q), 224'(2'd0));

    for (int v = 0; v < 11; v++) begin
      req = tbl[v].req;
      pe = 1'b1;
      tick();
      pe = 1'b0;
      exp_ack = tbl[v].vld ? (4'b0001 << tbl[v].id) : 4'b0000;
      chk($sformatf("v%0d_valid", v), 224'(valid), 224'(tbl[v].vld));
      chk($sformatf("v%0d_id", v), 224'(gid), 224'(tbl[v].id));
      chk($sformatf("v%0d_ack", v), 224'(ack), 224'(exp_ack));
      chk($sformatf("v%0d_header", v), 224'(header),
          224'(tbl[v].vld ? hdr_of(int'(tbl[v].id)) : 24'h0));
      chk($sformatf("v%0d_sub", v), sub, tbl[v].vld ? sub_of(int'(tbl[v].id)) : 224'h0);
      chk($sformatf("v%0d_rr", v), 224'(dut.rr_ptr_q), 224'(tbl[v].rr));
      req = 4'b0000;
      tick();
      chk($sformatf("v%0d_ack_pulse", v), 224'(ack), 224'(4'b0));
      chk($sformatf("v%0d_hold", v), 224'(header),
          224'(tbl[v].vld ? hdr_of(int'(tbl[v].id)) : 24'h0));
      tick(); tick();
    end

    fe = 1'b1; tick(); fe = 1'b0;
    chk("field1_missed", 224'(missed), 224'(4'b0000));

    // Urgent source hogs every slot for a whole field.
    req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      pe = 1'b1; tick(); pe = 1'b0;
      chk($sformatf("urg%0d_id", s), 224'(gid), 224'(2'd0));
      chk($sformatf("urg%0d_ack", s), 224'(ack), 224'(4'b0001));
      repeat (31) tick();
    end
    chk("urg_rr_kept", 224'(dut.rr_ptr_q), 224'(2'd3));
    req = 4'b0000;
    fe = 1'b1; tick(); fe = 1'b0;
    chk("urg_missed", 224'(missed), 224'(4'b0110));

    // Back-to-back strobes: the just-acked source is masked.
    tick();
    req = 4'b0010;
    pe = 1'b1; tick();
    chk("b2b_first_valid", 224'(valid), 224'(1'b1));
    chk("b2b_first_id", 224'(gid), 224'(2'd1));
    chk("b2b_first_ack", 224'(ack), 224'(4'b0010));
    tick();
    pe = 1'b0;
    chk("b2b_second_valid", 224'(valid), 224'(1'b0));
    chk("b2b_second_ack", 224'(ack), 224'(4'b0000));
    chk("b2b_second_header", 224'(header), 224'(24'h0));
    chk("b2b_second_id", 224'(gid), 224'(2'd1));
    chk("missed_sticky", 224'(missed), 224'(4'b0110));
    req = 4'b0000;
    tick(); tick();

    // Reset arriving mid-slot, then coincident with a strobe.
    req = 4'b0010;
    pe = 1'b1; tick(); pe = 1'b0;
    chk("midslot_valid", 224'(valid), 224'(1'b1));
    req = 4'b0000;
    repeat (9) tick();
    reset = 1'b1; tick();
    chk("midrst_header", 224'(header), 224'(24'h0));
    chk("midrst_valid", 224'(valid), 224'(1'b0));
    chk("midrst_missed", 224'(missed), 224'(4'b0));
    chk("midrst_rr", 224'(dut.rr_ptr_q), 224'(2'd0));
    req = 4'b0010; pe = 1'b1; tick();
    chk("rst_wins_valid", 224'(valid), 224'(1'b0));
    chk("rst_wins_ack", 224'(ack), 224'(4'b0));
    reset = 1'b0; pe = 1'b0; req = 4'b0000;
    tick();

    // Grant in the field-end cycle counts for the ending field.
    req = 4'b0010; pe = 1'b1; fe = 1'b1; tick();
    pe = 1'b0; fe = 1'b0; req = 4'b0000;
    chk("fe_grant_id", 224'(gid), 224'(2'd1));
    chk("fe_grant_valid", 224'(valid), 224'(1'b1));
    chk("fe_missed", 224'(missed), 224'(4'b0100));
    chk("fe_sent_clear", 224'(dut.sent_q), 224'(4'b0000));
    tick();

    // Wider urgent mask starves deadline source 2 (and 1) every field.
    req2 = 4'b0111;
    for (int s = 0; s < 2; s++) begin
      pe2 = 1'b1; tick(); pe2 = 1'b0;
      chk($sformatf("starve%0d_id", s), 224'(gid2), 224'(2'd0));
      chk($sformatf("starve%0d_ack", s), 224'(ack2), 224'(4'b0001));
      repeat (4) tick();
    end
    fe2 = 1'b1; tick(); fe2 = 1'b0;
    chk("starve_missed", 224'(missed2), 224'(4'b0110));
    pe2 = 1'b1; tick(); pe2 = 1'b0;
    repeat (4) tick();
    fe2 = 1'b1; tick(); fe2 = 1'b0;
    chk("starve_missed_sticky", 224'(missed2), 224'(4'b0110));
    req2 = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
